pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the multicycle CPU: owns the PC register, selects the next PC from the datapath sources, and handles exception/interrupt entry and `eret` return. It holds the EPC register, the cause code and the exception-level flag (EXL). It sits between the control FSM (write enables, source select, trap requests) and the instruction-fetch address path. It is the parametrised successor of the plain next-PC selector. Unused select codes hold the PC instead of latching.

## Interface
Parameters:
- `WIDTH`, 32, PC/data width; must be ≥ 8.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_0180, trap entry address.
- `INSTR_BYTES`, 4, instruction size; PC correction applied for synchronous exceptions.
- `IRQ_CODE`, 5'd0, cause code recorded for an interrupt.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `pc_src`  in  3  next-PC select:
  - 000 `alu_result`
  - 001 `alu_out`
  - 010 jump
  - 011 `reg_data`
  - 100 `epc_q`
  - 101 `EXC_VECTOR`
  - 110/111 hold
- `pc_write`  in  1  unconditional PC write.
- `pc_write_cond`  in  1  branch write; qualified by `zero`.
- `zero`  in  1  ALU zero flag.
- `alu_result`  in  WIDTH  ALU output this cycle (PC+4).
- `alu_out`  in  WIDTH  registered ALU output (branch target).
- `jump_target`  in  WIDTH-4  pre-shifted jump index; jump PC = {pc_q[WIDTH-1:WIDTH-4], jump_target}.
- `reg_data`  in  WIDTH  register-file read port 1 (jr).
- `exc_req`  in  1  synchronous exception request (overflow, syscall, illegal op).
- `exc_code`  in  5  cause for `exc_req`.
- `irq`  in  1  external interrupt, level.
- `irq_en`  in  1  global interrupt enable.
- `instr_boundary`  in  1  high in the fetch cycle where an interrupt may be taken.
- `eret`  in  1  return from trap.
- `pc_d`  out  WIDTH  combinational next-PC mux output.
- `pc_q`  out  WIDTH  current PC.
- `epc_q`  out  WIDTH  exception PC.
- `cause_q`  out  5  last trap cause.
- `exl_q`  out  1  exception level.
- `irq_pending`  out  1  sticky latched interrupt.
- `trap_taken`  out  1  one-cycle pulse on trap entry.

## Operation
- `pc_d` is fully combinational from `pc_src` and the data inputs. Codes 110/111 give `pc_q`. No latches.
- `irq_pending` sets in any cycle with `irq`=1. It clears only when an interrupt is taken; clear wins over set in that cycle.
- `irq_take` = `irq_pending` & `irq_en` & !`exl_q` & `instr_boundary` & !`exc_req`.
- Per-cycle priority; the highest applicable row acts exclusively:
  1. `exc_req`:
     - pc ← `EXC_VECTOR`; cause ← `exc_code`; `exl` ← 1; `trap_taken` ← 1.
     - epc ← `pc_q` − `INSTR_BYTES` (mod 2^WIDTH), only if `exl_q`=0.
     - With `exl_q`=1 the EPC is preserved (nested fault).
  2. `irq_take`:
     - pc ← `EXC_VECTOR`; epc ← `pc_q` (uncorrected); cause ← `IRQ_CODE`; `exl` ← 1.
     - `irq_pending` ← 0; `trap_taken` ← 1.
  3. `eret`:
     - pc ← `epc_q`; `exl` ← 0.
     - With `exl_q`=0 the PC is still loaded and EXL stays 0.
  4. `pc_write` | (`pc_write_cond` & `zero`): pc ← `pc_d`.
  5. Otherwise all registers hold.
- `trap_taken` is 0 in every cycle not covered by rows 1–2.
- Arithmetic wraps modulo 2^WIDTH. No overflow flagging.

## Timing
- Reset (async on `rst_n` low, released synchronously by the bench):
  - `pc_q`=`RESET_VECTOR`.
  - `epc_q`=0, `cause_q`=0, `exl_q`=0, `irq_pending`=0, `trap_taken`=0.
- Reset asserted mid-trap clears all state immediately, independent of `clk`.
- Latency:
  - PC write visible on `pc_q` one edge after the enable cycle.
  - Trap: `pc_q`=`EXC_VECTOR` and `trap_taken`=1 in the cycle after the request.
- An `irq` pulse of one cycle must be captured. An interrupt is taken no earlier than the next `instr_boundary` after capture.
- Simultaneous `exc_req` and a takeable interrupt: the exception wins and `irq_pending` stays set for a later boundary.
- Simultaneous `eret` and `pc_write`: `eret` wins.

## Test plan
- Reset, then `pc_src`=000, `alu_result`=0x4, `pc_write`=1 → `pc_q`=0x4 next cycle; reset values verified before the write.
- Branch:
  - `pc_write_cond`=1, `zero`=0, `alu_out`=0x100 → `pc_q` unchanged.
  - Then `zero`=1 → `pc_q`=0x100.
  - Jump with `pc_q`=0x4000_0010, `jump_target`=0x0000_200 → `pc_q`=0x4000_0200.
- `exc_req`=1, `exc_code`=12, `pc_q`=0x24 → `pc_q`=0x180, `epc_q`=0x20, `cause_q`=12, `exl_q`=1, `trap_taken` one-cycle pulse. A second `exc_req` leaves `epc_q`=0x20.
- Interrupt:
  - `irq` one-cycle pulse with `irq_en`=1, `instr_boundary`=0 → `irq_pending`=1, no trap.
  - At the boundary with `pc_q`=0x40 → `pc_q`=0x180, `epc_q`=0x40, `cause_q`=0, `irq_pending`=0.
  - With `irq_en`=0 or `exl_q`=1 the interrupt is not taken and stays pending.
- `eret` after a trap → `pc_q`=`epc_q`, `exl_q`=0. Same cycle with `exc_req`=1 → exception wins.
- `pc_src`=110 with `pc_write`=1 → `pc_q` holds. Assert `rst_n`=0 mid-cycle with `exl_q`=1 → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control-side bundle of the PC sequencer: the selects, data sources and trap requests from
// the control FSM and datapath, and the PC/EPC/cause/EXL state returned to the fetch path.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       pc_src;
    logic             pc_write;
    logic             pc_write_cond;
    logic             zero;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-5:0] jump_target;
    logic [WIDTH-1:0] reg_data;
    logic             exc_req;
    logic [4:0]       exc_code;
    logic             irq;
    logic             irq_en;
    logic             instr_boundary;
    logic             eret;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [4:0]       cause_q;
    logic             exl_q;
    logic             irq_pending;
    logic             trap_taken;

    modport master (
        output pc_src, pc_write, pc_write_cond, zero, alu_result, alu_out, jump_target,
               reg_data, exc_req, exc_code, irq, irq_en, instr_boundary, eret,
        input  pc_d, pc_q, epc_q, cause_q, exl_q, irq_pending, trap_taken
    );

    modport slave (
        input  pc_src, pc_write, pc_write_cond, zero, alu_result, alu_out, jump_target,
               reg_data, exc_req, exc_code, irq, irq_en, instr_boundary, eret,
        output pc_d, pc_q, epc_q, cause_q, exl_q, irq_pending, trap_taken
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register with next-PC select, synchronous exception / interrupt entry and eret return.
// Holds EPC, cause and the exception-level flag; the interrupt line is latched until taken.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int               INSTR_BYTES  = 4,
    parameter logic [4:0]       IRQ_CODE     = 5'd0
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam logic [2:0] SRC_ALU_RESULT = 3'b000;
    localparam logic [2:0] SRC_ALU_OUT    = 3'b001;
    localparam logic [2:0] SRC_JUMP       = 3'b010;
    localparam logic [2:0] SRC_REG        = 3'b011;
    localparam logic [2:0] SRC_EPC        = 3'b100;
    localparam logic [2:0] SRC_EXC        = 3'b101;

    logic [WIDTH-1:0] pc_q, pc_nxt;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [4:0]       cause_q, cause_d;
    logic             exl_q, exl_d;
    logic             irq_pending_q, irq_pending_d;
    logic             trap_taken_q, trap_taken_d;
    logic [WIDTH-1:0] pc_sel;
    logic             irq_take;

    always_comb begin
        pc_sel = pc_q;
        case (bus.pc_src)
            SRC_ALU_RESULT: pc_sel = bus.alu_result;
            SRC_ALU_OUT:    pc_sel = bus.alu_out;
            SRC_JUMP:       pc_sel = {pc_q[WIDTH-1:WIDTH-4], bus.jump_target};
            SRC_REG:        pc_sel = bus.reg_data;
            SRC_EPC:        pc_sel = epc_q;
            SRC_EXC:        pc_sel = EXC_VECTOR;
            default:        pc_sel = pc_q;
        endcase
    end

    assign irq_take = irq_pending_q & bus.irq_en & ~exl_q & bus.instr_boundary & ~bus.exc_req;

    always_comb begin
        pc_nxt        = pc_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        exl_d         = exl_q;
        irq_pending_d = irq_pending_q | bus.irq;
        trap_taken_d  = 1'b0;
        if (bus.exc_req) begin
            pc_nxt       = EXC_VECTOR;
            cause_d      = bus.exc_code;
            exl_d        = 1'b1;
            trap_taken_d = 1'b1;
            // A nested fault keeps the EPC of the original trap.
            if (!exl_q) begin
                epc_d = pc_q - WIDTH'(INSTR_BYTES);
            end
        end else if (irq_take) begin
            pc_nxt        = EXC_VECTOR;
            epc_d         = pc_q;
            cause_d       = IRQ_CODE;
            exl_d         = 1'b1;
            irq_pending_d = 1'b0;
            trap_taken_d  = 1'b1;
        end else if (bus.eret) begin
            pc_nxt = epc_q;
            exl_d  = 1'b0;
        end else if (bus.pc_write || (bus.pc_write_cond && bus.zero)) begin
            pc_nxt = pc_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            cause_q       <= '0;
            exl_q         <= 1'b0;
            irq_pending_q <= 1'b0;
            trap_taken_q  <= 1'b0;
        end else begin
            pc_q          <= pc_nxt;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            exl_q         <= exl_d;
            irq_pending_q <= irq_pending_d;
            trap_taken_q  <= trap_taken_d;
        end
    end

    assign bus.pc_d        = pc_sel;
    assign bus.pc_q        = pc_q;
    assign bus.epc_q       = epc_q;
    assign bus.cause_q     = cause_q;
    assign bus.exl_q       = exl_q;
    assign bus.irq_pending = irq_pending_q;
    assign bus.trap_taken  = trap_taken_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the trap/branch scenarios with literal
// expectations, then randomized traffic, all compared against a behavioural model every cycle.
module tb_pc_sequencer;
    localparam int          W   = 32;
    localparam logic [31:0] EXC = 32'h0000_0180;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(
        .WIDTH(W),
        .RESET_VECTOR(32'h0),
        .EXC_VECTOR(EXC),
        .INSTR_BYTES(4),
        .IRQ_CODE(5'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_en = 0;

    logic [31:0] m_pc, m_epc, n_pc, n_epc;
    logic [4:0]  m_cause, n_cause;
    logic        m_exl, m_pend, m_trap, n_exl, n_pend, n_trap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_mux();
        case (bus.pc_src)
            3'd0:    return bus.alu_result;
            3'd1:    return bus.alu_out;
            3'd2:    return {m_pc[31:28], bus.jump_target};
            3'd3:    return bus.reg_data;
            3'd4:    return m_epc;
            3'd5:    return EXC;
            default: return m_pc;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_cause = 5'd0;
        m_exl = 1'b0; m_pend = 1'b0; m_trap = 1'b0;
    endtask

    // Next architectural state from the priority rules: exception, interrupt, eret, PC write.
    task automatic calc_next();
        bit take;
        n_pc = m_pc; n_epc = m_epc; n_cause = m_cause; n_exl = m_exl;
        take   = m_pend && bus.irq_en && !m_exl && bus.instr_boundary && !bus.exc_req;
        n_pend = (m_pend || bus.irq) && !take;
        n_trap = bus.exc_req || take;
        if (bus.exc_req) begin
            n_pc = EXC; n_cause = bus.exc_code; n_exl = 1'b1;
            if (!m_exl) n_epc = m_pc - 32'd4;
        end else if (take) begin
            n_pc = EXC; n_epc = m_pc; n_cause = 5'd0; n_exl = 1'b1;
        end else if (bus.eret) begin
            n_pc = m_epc; n_exl = 1'b0;
        end else if (bus.pc_write || (bus.pc_write_cond && bus.zero)) begin
            n_pc = model_mux();
        end
        if (!rst_n) begin
            n_pc = 32'h0; n_epc = 32'h0; n_cause = 5'd0;
            n_exl = 1'b0; n_pend = 1'b0; n_trap = 1'b0;
        end
    endtask

    task automatic idle();
        bus.pc_src = 3'd0; bus.pc_write = 0; bus.pc_write_cond = 0; bus.zero = 0;
        bus.alu_result = '0; bus.alu_out = '0; bus.jump_target = '0; bus.reg_data = '0;
        bus.exc_req = 0; bus.exc_code = '0; bus.irq = 0; bus.irq_en = 0;
        bus.instr_boundary = 0; bus.eret = 0;
    endtask

    task automatic step();
        calc_next();
        @(posedge clk);
        #1;
        m_pc = n_pc; m_epc = n_epc; m_cause = n_cause;
        m_exl = n_exl; m_pend = n_pend; m_trap = n_trap;
        idle();
    endtask

    task automatic load_pc(input logic [31:0] v);
        bus.pc_src = 3'd3; bus.reg_data = v; bus.pc_write = 1;
        step();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc_q",        bus.pc_q,        m_pc);
            chk("pc_d",        bus.pc_d,        model_mux());
            chk("epc_q",       bus.epc_q,       m_epc);
            chk("cause_q",     32'(bus.cause_q), 32'(m_cause));
            chk("exl_q",       32'(bus.exl_q),  32'(m_exl));
            chk("irq_pending", 32'(bus.irq_pending), 32'(m_pend));
            chk("trap_taken",  32'(bus.trap_taken),  32'(m_trap));
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        cmp_en = 1;
        chk("rst pc", bus.pc_q, 32'h0);
        chk("rst epc", bus.epc_q, 32'h0);
        chk("rst exl", 32'(bus.exl_q), 32'h0);
        chk("rst trap", 32'(bus.trap_taken), 32'h0);

        bus.pc_src = 3'd0; bus.alu_result = 32'h4; bus.pc_write = 1;
        step();
        chk("write pc", bus.pc_q, 32'h4);

        bus.pc_src = 3'd1; bus.alu_out = 32'h100; bus.pc_write_cond = 1; bus.zero = 0;
        step();
        chk("branch nt", bus.pc_q, 32'h4);
        bus.pc_src = 3'd1; bus.alu_out = 32'h100; bus.pc_write_cond = 1; bus.zero = 1;
        step();
        chk("branch t", bus.pc_q, 32'h100);

        load_pc(32'h4000_0010);
        bus.pc_src = 3'd2; bus.jump_target = 28'h000_0200;
        #1 chk("jump pc_d", bus.pc_d, 32'h4000_0200);
        bus.pc_write = 1;
        step();
        chk("jump pc", bus.pc_q, 32'h4000_0200);

        load_pc(32'h24);
        bus.exc_req = 1; bus.exc_code = 5'd12;
        step();
        chk("exc pc", bus.pc_q, 32'h180);
        chk("exc epc", bus.epc_q, 32'h20);
        chk("exc cause", 32'(bus.cause_q), 32'd12);
        chk("exc trap", 32'(bus.trap_taken), 32'h1);
        step();
        chk("trap pulse end", 32'(bus.trap_taken), 32'h0);
        bus.exc_req = 1; bus.exc_code = 5'd4;
        step();
        chk("nested epc", bus.epc_q, 32'h20);
        bus.eret = 1;
        step();
        chk("eret pc", bus.pc_q, 32'h20);
        chk("eret exl", 32'(bus.exl_q), 32'h0);

        load_pc(32'h40);
        bus.irq = 1; bus.irq_en = 1;
        step();
        chk("irq latched", 32'(bus.irq_pending), 32'h1);
        chk("irq no trap", 32'(bus.trap_taken), 32'h0);
        bus.irq_en = 1; bus.instr_boundary = 1;
        step();
        chk("irq pc", bus.pc_q, 32'h180);
        chk("irq epc", bus.epc_q, 32'h40);
        chk("irq cause", 32'(bus.cause_q), 32'h0);
        chk("irq cleared", 32'(bus.irq_pending), 32'h0);

        bus.irq = 1;
        step();
        bus.irq_en = 1; bus.instr_boundary = 1;
        step();
        chk("irq blocked exl", 32'(bus.irq_pending), 32'h1);
        chk("irq blocked pc", bus.pc_q, 32'h180);
        bus.eret = 1;
        step();
        bus.irq_en = 0; bus.instr_boundary = 1;
        step();
        chk("irq blocked en", 32'(bus.irq_pending), 32'h1);
        bus.irq_en = 1; bus.instr_boundary = 1; bus.exc_req = 1; bus.exc_code = 5'd9;
        step();
        chk("exc over irq cause", 32'(bus.cause_q), 32'd9);
        chk("exc over irq pend", 32'(bus.irq_pending), 32'h1);
        bus.eret = 1; bus.exc_req = 1; bus.exc_code = 5'd10;
        step();
        chk("exc over eret", 32'(bus.exl_q), 32'h1);
        chk("exc over eret pc", bus.pc_q, 32'h180);
        bus.eret = 1; bus.pc_write = 1; bus.pc_src = 3'd0; bus.alu_result = 32'h888;
        step();
        chk("eret over write", bus.pc_q, 32'h3c);
        bus.pc_src = 3'd6; bus.pc_write = 1;
        step();
        chk("hold code", bus.pc_q, 32'h3c);

        bus.exc_req = 1; bus.exc_code = 5'd7;
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst pc", bus.pc_q, 32'h0);
        chk("async rst exl", 32'(bus.exl_q), 32'h0);
        chk("async rst cause", 32'(bus.cause_q), 32'h0);
        chk("async rst pend", 32'(bus.irq_pending), 32'h0);
        chk("async rst trap", 32'(bus.trap_taken), 32'h0);
        step();
        rst_n = 1'b1;
        bus.exc_req = 1; bus.exc_code = 5'd3;
        step();
        chk("epc wrap", bus.epc_q, 32'hFFFF_FFFC);
        bus.eret = 1;
        step();

        for (int i = 0; i < 600; i++) begin
            bus.pc_src         = 3'($urandom_range(0, 7));
            bus.pc_write       = ($urandom_range(0, 2) == 0);
            bus.pc_write_cond  = ($urandom_range(0, 3) == 0);
            bus.zero           = 1'($urandom);
            bus.alu_result     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            bus.alu_out        = $urandom;
            bus.jump_target    = 28'($urandom);
            bus.reg_data       = $urandom;
            bus.exc_req        = ($urandom_range(0, 9) == 0);
            bus.exc_code       = 5'($urandom);
            bus.irq            = ($urandom_range(0, 5) == 0);
            bus.irq_en         = ($urandom_range(0, 3) != 0);
            bus.instr_boundary = ($urandom_range(0, 2) == 0);
            bus.eret           = ($urandom_range(0, 7) == 0);
            step();
        end

        @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
